gpu_rect_fill_engine: RTL and testbench

//  Downstream consumer of the GPU controller AXI4-Lite register bank: takes rectangle-fill

---
 rtl/gpu_pkg.sv | 15 +
 rtl/gpu_cmd_fifo.sv | 44 ++++
 rtl/gpu_rect_fill_engine.sv | 118 +++++++++++
 tb/tb_gpu_rect_fill_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared command record, FSM states and framebuffer defaults for the rect fill engine.
package gpu_pkg;
  localparam int DEF_FB_WIDTH  = 640;
  localparam int DEF_FB_HEIGHT = 480;
  localparam int DEF_COORD_W   = 10;
  localparam int DEF_COLOR_W   = 8;
  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_COORD_W-1:0] w;
    logic [DEF_COORD_W-1:0] h;
    logic [DEF_COLOR_W-1:0] color;
  } fill_cmd_t;
  typedef enum logic [1:0] {IDLE, LOAD, FILL} fill_state_e;
endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: synchronous FIFO of fill commands with flush; flush beats push and pop.
module gpu_cmd_fifo
  import gpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fill_cmd_t     din,
  output fill_cmd_t     dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  fill_cmd_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = level == FULL_LVL;
  assign empty   = level == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/gpu_rect_fill_engine.sv
// gpu_rect_fill_engine: queues rectangle-fill commands and streams one pixel write per cycle.
// Define GPU_FILL_CLIP_EN to clip every rectangle to the framebuffer.
module gpu_rect_fill_engine
  import gpu_pkg::*;
#(
  parameter  int FB_WIDTH  = DEF_FB_WIDTH,
  parameter  int FB_HEIGHT = DEF_FB_HEIGHT,
  parameter  int COORD_W   = DEF_COORD_W,
  parameter  int COLOR_W   = DEF_COLOR_W,
  parameter  int ADDR_W    = 19,
  parameter  int CMD_DEPTH = 4,
  localparam int LW        = $clog2(CMD_DEPTH) + 1
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               sw_clear,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [COLOR_W-1:0] pix_data,
  output logic               busy,
  output logic               done,
  output logic [LW-1:0]      fifo_level
);
  localparam int CW1 = COORD_W + 1;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);
  if (ADDR_W < $clog2(FB_WIDTH * FB_HEIGHT)) begin : g_addr_chk
    $error("ADDR_W cannot address the framebuffer");
  end
  fill_state_e state, state_nx;
  fill_cmd_t cmd_in, head, cmd;
  logic full, empty, pop, fire, row_last, last, load_empty;
  logic [COORD_W:0] cx, cy, x_end, y_end, sum_x, sum_y, x_end_ld, y_end_ld;
  logic [ADDR_W-1:0] row_base;
  assign cmd_in = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color};
  gpu_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .flush (sw_clear),
    .push  (cmd_valid),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  assign cmd_ready = !full;
  assign busy      = state != IDLE || !empty;
  assign pix_valid = state == FILL;
  assign pix_addr  = row_base + ADDR_W'(cx);
  assign fire      = pix_valid && pix_ready;
  assign row_last  = cx == x_end - 1'b1;
  assign last      = row_last && cy == y_end - 1'b1;
  assign pop       = state == IDLE && !empty && !sw_clear;
  assign sum_x     = {1'b0, cmd.x} + {1'b0, cmd.w};
  assign sum_y     = {1'b0, cmd.y} + {1'b0, cmd.h};
`ifdef GPU_FILL_CLIP_EN
  localparam logic [COORD_W:0] X_LIM = CW1'(FB_WIDTH);
  localparam logic [COORD_W:0] Y_LIM = CW1'(FB_HEIGHT);
  assign x_end_ld   = sum_x > X_LIM ? X_LIM : sum_x;
  assign y_end_ld   = sum_y > Y_LIM ? Y_LIM : sum_y;
  assign load_empty = cmd.w == '0 || cmd.h == '0 || {1'b0, cmd.x} >= X_LIM || {1'b0, cmd.y} >= Y_LIM;
`else
  assign x_end_ld   = sum_x;
  assign y_end_ld   = sum_y;
  assign load_empty = cmd.w == '0 || cmd.h == '0;
`endif
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (sw_clear) state_nx = IDLE;
    else case (state)
      IDLE:    state_nx = empty ? IDLE : LOAD;
      LOAD:    state_nx = load_empty ? IDLE : FILL;
      FILL:    state_nx = fire && last ? IDLE : FILL;
      default: state_nx = IDLE;
    endcase
  end
  // The only multiply happens in LOAD; each later row just adds one framebuffer width.
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      cmd      <= '0;
      cx       <= '0;
      cy       <= '0;
      x_end    <= '0;
      y_end    <= '0;
      row_base <= '0;
      pix_data <= '0;
      done     <= 1'b0;
    end else begin
      done <= !sw_clear && ((state == LOAD && load_empty) || (fire && last));
      if (pop) cmd <= head;
      if (state == LOAD) begin
        cx       <= {1'b0, cmd.x};
        cy       <= {1'b0, cmd.y};
        x_end    <= x_end_ld;
        y_end    <= y_end_ld;
        row_base <= ADDR_W'(cmd.y) * ROW_STEP;
        pix_data <= cmd.color;
      end else if (fire) begin
        cx <= row_last ? {1'b0, cmd.x} : cx + 1'b1;
        if (row_last) begin
          row_base <= row_base + ROW_STEP;
          cy       <= cy + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_gpu_rect_fill_engine.sv
// tb_gpu_rect_fill_engine: vector table, hand sequences and randomized commands against a pixel-list model.
module tb_gpu_rect_fill_engine;
  logic clk = 0, rst_n = 1;
  logic cmd_valid = 0, sw_clear = 0, pix_ready = 0;
  logic [9:0] cmd_x = 0, cmd_y = 0, cmd_w = 0, cmd_h = 0;
  logic [7:0] cmd_color = 0;
  logic cmd_ready, pix_valid, busy, done;
  logic [18:0] pix_addr;
  logic [7:0] pix_data;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  gpu_rect_fill_engine dut (
    .ACLK(clk), .ARESETN(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .sw_clear(sw_clear), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr),
    .pix_data(pix_data), .busy(busy), .done(done), .fifo_level(fifo_level)
  );

  typedef struct { int a; int d; } pix_t;
  typedef struct { int x; int y; int w; int h; int c; int npix; int first; int last; } vec_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int checks = 0, failures = 0, done_cnt = 0, exp_done = 0, hs_cnt = 0, first_a = 0, last_a = 0;
  logic held = 0;
  logic [18:0] hold_a = 0;
  logic [7:0] hold_d = 0;
  bit rand_rdy = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, req);
    end
  endtask

  // Reference: a rectangle is the raster-ordered list of its in-range pixels.
  task automatic model_cmd(input int x, input int y, input int w, input int h, input int c);
    int xe = x + w;
    int ye = y + h;
`ifdef GPU_FILL_CLIP_EN
    if (xe > 640) xe = 640;
    if (ye > 480) ye = 480;
`endif
    for (int r = y; r < ye; r++)
      for (int q = x; q < xe; q++) exp_q.push_back('{(r * 640 + q) % 524288, c});
    exp_done++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (held && pix_valid) begin
        chk("hold_addr", 32'(pix_addr), 32'(hold_a));
        chk("hold_data", 32'(pix_data), 32'(hold_d));
      end
      held = pix_valid && !pix_ready;
      hold_a = pix_addr;
      hold_d = pix_data;
      if (pix_valid && pix_ready) begin
        chk("pix_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("pix_addr", 32'(pix_addr), mon_e.a);
          chk("pix_data", 32'(pix_data), mon_e.d);
        end
        if (hs_cnt == 0) first_a = 32'(pix_addr);
        last_a = 32'(pix_addr);
        hs_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) pix_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input int x, input int y, input int w, input int h, input int c);
    int n = 0;
    logic hs = 0;
    cmd_x = 10'(x);
    cmd_y = 10'(y);
    cmd_w = 10'(w);
    cmd_h = 10'(h);
    cmd_color = 8'(c);
    cmd_valid = 1;
    do begin
      hs = cmd_ready;
      step();
      n++;
    end while (!hs && n < 300);
    cmd_valid = 0;
    chk("push_accept", 32'(hs), 1);
    if (hs) model_cmd(x, y, w, h, c);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_time", 32'(n < budget), 1);
    step();
    step();
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({t, "_pix_valid"}, 32'(pix_valid), 0);
    chk({t, "_pix_addr"}, 32'(pix_addr), 0);
    chk({t, "_pix_data"}, 32'(pix_data), 0);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_done"}, 32'(done), 0);
    chk({t, "_fifo_level"}, 32'(fifo_level), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int d0, n, x, y;
    tbl[0] = '{2, 3, 2, 2, 'h5A, 4, 1922, 2563};
    tbl[1] = '{0, 0, 1, 1, 'h11, 1, 0, 0};
    tbl[2] = '{639, 479, 1, 1, 'h22, 1, 307199, 307199};
    tbl[3] = '{10, 0, 0, 5, 'h33, 0, 0, 0};
    tbl[4] = '{5, 1, 3, 1, 'h44, 3, 645, 647};
`ifdef GPU_FILL_CLIP_EN
    tbl[5] = '{638, 479, 4, 4, 'h55, 2, 307198, 307199};
    tbl[6] = '{700, 10, 2, 2, 'h66, 0, 0, 0};
    tbl[7] = '{0, 1000, 1, 1, 'h77, 0, 0, 0};
`else
    tbl[5] = '{638, 479, 4, 4, 'h55, 16, 307198, 309121};
    tbl[6] = '{700, 10, 2, 2, 'h66, 4, 7100, 7741};
    tbl[7] = '{0, 1000, 1, 1, 'h77, 1, 115712, 115712};
`endif
    tbl[8] = '{3, 0, 2, 3, 'h88, 6, 3, 1284};

    #1 rst_n = 0;
    #2 chk_reset("rst");
    #9 rst_n = 1;
    step();

    // First-pixel latency and the done pulse timing
    pix_ready = 1;
    d0 = done_cnt;
    hs_cnt = 0;
    push(2, 3, 2, 2, 'h5A);
    chk("t1_busy", 32'(busy), 1);
    @(negedge clk) chk("t1_idle_valid", 32'(pix_valid), 0);
    @(negedge clk) chk("t1_load_valid", 32'(pix_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(pix_valid), 1);
      chk("t1_done_early", 32'(done), 0);
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 1);
    chk("t1_valid_off", 32'(pix_valid), 0);
    @(negedge clk);
    chk("t1_done_once", 32'(done), 0);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_hs", hs_cnt, 4);
    chk("t1_first", first_a, 1922);
    chk("t1_done_cnt", done_cnt - d0, 1);
    step();

    for (int i = 0; i < 9; i++) begin
      d0 = done_cnt;
      hs_cnt = 0;
      push(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c);
      drain(200);
      chk($sformatf("tbl%0d_npix", i), hs_cnt, tbl[i].npix);
      chk($sformatf("tbl%0d_done", i), done_cnt - d0, 1);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 0);
      if (tbl[i].npix > 0) begin
        chk($sformatf("tbl%0d_first", i), first_a, tbl[i].first);
        chk($sformatf("tbl%0d_last", i), last_a, tbl[i].last);
      end
    end

    // Back-pressure fills the queue; a sixth command must wait, nothing is lost
    pix_ready = 0;
    d0 = done_cnt;
    hs_cnt = 0;
    for (int i = 0; i < 5; i++) push(10 * i, 20 + i, 2, 1, 'hA0 + i);
    chk("t3_level", 32'(fifo_level), 4);
    chk("t3_ready_low", 32'(cmd_ready), 0);
    cmd_x = 1;
    cmd_y = 1;
    cmd_w = 1;
    cmd_h = 1;
    cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_level_hold", 32'(fifo_level), 4);
      chk("t3_ready_hold", 32'(cmd_ready), 0);
    end
    cmd_valid = 0;
    pix_ready = 1;
    drain(300);
    chk("t3_hs", hs_cnt, 10);
    chk("t3_done", done_cnt - d0, 5);

    // Random stalls during a 3x3 fill
    d0 = done_cnt;
    hs_cnt = 0;
    rand_rdy = 1;
    push(100, 200, 3, 3, 'hC3);
    drain(300);
    rand_rdy = 0;
    pix_ready = 1;
    chk("t4_hs", hs_cnt, 9);
    chk("t4_done", done_cnt - d0, 1);

    // sw_clear mid-fill with two queued, plus a coincident push
    pix_ready = 0;
    d0 = done_cnt;
    hs_cnt = 0;
    push(0, 0, 3, 3, 1);
    push(0, 10, 3, 3, 2);
    push(0, 20, 3, 3, 3);
    n = 0;
    while (!pix_valid && n < 20) begin
      step();
      n++;
    end
    chk("t6_fill_started", 32'(pix_valid), 1);
    chk("t6_level", 32'(fifo_level), 2);
    pix_ready = 1;
    step();
    step();
    pix_ready = 0;
    sw_clear = 1;
    cmd_w = 1;
    cmd_h = 1;
    cmd_valid = 1;
    step();
    sw_clear = 0;
    cmd_valid = 0;
    chk("t6_valid", 32'(pix_valid), 0);
    chk("t6_level0", 32'(fifo_level), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_ready", 32'(cmd_ready), 1);
    exp_q.delete();
    exp_done -= 3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_stay_idle", 32'(pix_valid), 0);
    end
    chk("t6_hs", hs_cnt, 2);
    chk("t6_no_done", done_cnt - d0, 0);

    // Asynchronous reset in the middle of a fill
    push(5, 5, 2, 2, 'h99);
    n = 0;
    while (!pix_valid && n < 20) begin
      step();
      n++;
    end
    chk("t7_fill_started", 32'(pix_valid), 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk_reset("t7");
    exp_q.delete();
    exp_done -= 1;
    @(negedge clk) rst_n = 1;
    step();

    d0 = done_cnt;
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 479));
      push(x, y, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) step();
    end
    drain(4000);
    rand_rdy = 0;
    pix_ready = 1;
    chk("rand_done", done_cnt - d0, 40);

    chk("done_total", done_cnt, exp_done);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
